// File: rtl/ps2_kbd_ctl_if.sv
// rtl/ps2_kbd_ctl_if.sv - signal bundle between PS/2 datapath, host logic and the keyboard controller
interface ps2_kbd_ctl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       led_req;
    logic [2:0] led_mask;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       led_busy;
    logic       led_fail;
    logic       kbd_err;

    modport master (
        output rx_data, rx_valid, rx_err, tx_busy, led_req, led_mask,
        input  tx_data, tx_start, key_code, key_ext, key_break, key_valid,
               led_busy, led_fail, kbd_err
    );

    modport slave (
        input  rx_data, rx_valid, rx_err, tx_busy, led_req, led_mask,
        output tx_data, tx_start, key_code, key_ext, key_break, key_valid,
               led_busy, led_fail, kbd_err
    );
endinterface

// File: rtl/ps2_kbd_ctl.sv
// rtl/ps2_kbd_ctl.sv - PS/2 keyboard controller: set-2 key event decoder and LED command sequencer
module ps2_kbd_ctl #(
    parameter int ACK_TIMEOUT = 500000,
    parameter int RETRIES     = 2
) (
    input logic          clk,
    input logic          reset_n,
    ps2_kbd_ctl_if.slave bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(RETRIES + 2);

    typedef enum logic [1:0] {P_NONE, P_E0, P_F0, P_E0F0} pfx_t;
    typedef enum logic [1:0] {C_IDLE, C_SEND, C_WAIT, C_DONE} cmd_t;

    pfx_t          pfx;
    logic [7:0]    key_code_q;
    logic          key_ext_q;
    logic          key_break_q;
    logic          key_valid_q;
    logic          kbd_err_q;

    cmd_t          state;
    cmd_t          state_nxt;
    logic          pend;
    logic [2:0]    pend_mask;
    logic [2:0]    mask;
    logic          idx;
    logic [RW-1:0] retry;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          led_fail_q;

    logic          rx_ok;
    logic          is_ack;
    logic          is_nak;
    logic          in_break;
    logic          pfx_err;
    logic          reply_err;
    logic          timeout;
    logic          can_retry;
    logic          tx_start_c;
    logic [7:0]    tx_data_c;
    logic          led_busy_c;

    assign rx_ok     = bus.rx_valid && !bus.rx_err;
    assign is_ack    = rx_ok && (bus.rx_data == 8'hFA);
    assign is_nak    = rx_ok && (bus.rx_data == 8'hFE);
    assign in_break  = (pfx == P_F0) || (pfx == P_E0F0);
    // A second prefix after F0 can never form a valid set-2 sequence
    assign pfx_err   = rx_ok && in_break && ((bus.rx_data == 8'hE0) || (bus.rx_data == 8'hF0));
    assign reply_err = (is_ack || is_nak) && ((state == C_IDLE) || (state == C_SEND));
    assign timer_inc = timer + TW'(1);
    assign timeout   = (state == C_WAIT) && (timer_inc == TW'(ACK_TIMEOUT - 1));
    assign can_retry = retry < RW'(RETRIES);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pfx         <= P_NONE;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
            kbd_err_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            kbd_err_q   <= bus.rx_err || pfx_err || reply_err;
            if (bus.rx_err) begin
                pfx <= P_NONE;
            end else if (bus.rx_valid) begin
                case (bus.rx_data)
                    8'hE0:        pfx <= in_break ? P_NONE : P_E0;
                    8'hF0:        pfx <= in_break ? P_NONE : ((pfx == P_E0) ? P_E0F0 : P_F0);
                    8'hFA, 8'hFE: pfx <= pfx;
                    8'hAA, 8'hFC: pfx <= P_NONE;
                    default: begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= bus.rx_data;
                        key_ext_q   <= (pfx == P_E0) || (pfx == P_E0F0);
                        key_break_q <= in_break;
                        pfx         <= P_NONE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= C_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            C_IDLE: if (pend) state_nxt = C_SEND;
            C_SEND: if (!bus.tx_busy) state_nxt = C_WAIT;
            C_WAIT: begin
                if (is_ack) begin
                    state_nxt = idx ? C_DONE : C_SEND;
                end else if (is_nak || timeout) begin
                    state_nxt = can_retry ? C_SEND : C_DONE;
                end
            end
            C_DONE: state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        tx_start_c = 1'b0;
        tx_data_c  = 8'h00;
        led_busy_c = 1'b1;
        case (state)
            C_IDLE: led_busy_c = pend;
            C_SEND: begin
                tx_start_c = !bus.tx_busy;
                tx_data_c  = idx ? {5'b00000, mask} : 8'hED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend       <= 1'b0;
            pend_mask  <= 3'b000;
            mask       <= 3'b000;
            idx        <= 1'b0;
            retry      <= '0;
            timer      <= '0;
            led_fail_q <= 1'b0;
        end else begin
            if ((state == C_IDLE) && pend) begin
                mask       <= pend_mask;
                idx        <= 1'b0;
                pend       <= 1'b0;
                led_fail_q <= 1'b0;
            end
            // A request arriving while busy overwrites whatever is still queued
            if (bus.led_req) begin
                pend      <= 1'b1;
                pend_mask <= bus.led_mask;
                if (state == C_IDLE) led_fail_q <= 1'b0;
            end
            case (state)
                C_SEND: if (!bus.tx_busy) timer <= '0;
                C_WAIT: begin
                    timer <= timer_inc;
                    if (is_ack) begin
                        if (!idx) begin
                            idx   <= 1'b1;
                            retry <= '0;
                        end
                    end else if (is_nak || timeout) begin
                        if (can_retry) retry <= retry + RW'(1);
                        else led_fail_q <= 1'b1;
                    end
                end
                C_DONE: retry <= '0;
                default: ;
            endcase
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_break = key_break_q;
    assign bus.key_valid = key_valid_q;
    assign bus.kbd_err   = kbd_err_q;
    assign bus.tx_start  = tx_start_c;
    assign bus.tx_data   = tx_data_c;
    assign bus.led_busy  = led_busy_c;
    assign bus.led_fail  = led_fail_q;
endmodule

// File: tb/tb_ps2_kbd_ctl.sv
// tb/tb_ps2_kbd_ctl.sv - directed self-checking bench for ps2_kbd_ctl
module tb_ps2_kbd_ctl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_kbd_ctl_if bus();

    ps2_kbd_ctl #(.ACK_TIMEOUT(100), .RETRIES(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] txq[$];
    int         txcyc[$];
    int         errp = 0;
    bit         watch_busy = 1'b0;
    int         busy_drop = 0;

    always @(negedge clk) begin
        if (bus.key_valid === 1'b1) evq.push_back(ev_t'{bus.key_code, bus.key_ext, bus.key_break});
        if (bus.kbd_err === 1'b1) errp++;
        if (bus.tx_start === 1'b1) begin
            txq.push_back(bus.tx_data);
            txcyc.push_back(cyc);
        end
        if (watch_busy && bus.led_busy !== 1'b1) busy_drop++;
    end

    function automatic logic [22:0] all_outs();
        return {bus.tx_data, bus.tx_start, bus.key_code, bus.key_ext, bus.key_break,
                bus.key_valid, bus.led_busy, bus.led_fail, bus.kbd_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        evq.delete();
        txq.delete();
        txcyc.delete();
        errp = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_led(input logic [2:0] m);
        bus.led_mask = m;
        bus.led_req  = 1'b1;
        tick();
        bus.led_req  = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int i;
        i = 0;
        while (txq.size() < n && i < 1000) begin
            tick();
            i++;
        end
        checks++;
        if (txq.size() < n) begin
            errors++;
            $display("FAIL %s: tx_start count %0d, required %0d", tag, txq.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (all_outs() !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        clear_logs();
        bus.rx_data  = 8'h1C;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: key_valid %b, required 0", bus.key_valid);
        end
        tick();
        bus.rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h1C) begin
            errors++;
            $display("FAIL latency_one: key_valid %b code %h, required 1 1c", bus.key_valid, bus.key_code);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key_code !== 8'h1C) begin
            errors++;
            $display("FAIL key_hold: key_valid %b code %h, required 0 1c", bus.key_valid, bus.key_code);
        end
        tick();
    endtask

    task automatic test_make_break();
        logic [7:0] bytes[8];
        ev_t        exp[4];
        bytes = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        exp   = '{ev_t'{8'h1C, 1'b0, 1'b0}, ev_t'{8'h1C, 1'b0, 1'b1},
                  ev_t'{8'h75, 1'b1, 1'b0}, ev_t'{8'h75, 1'b1, 1'b1}};
        clear_logs();
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        repeat (2) tick();
        checks++;
        if (evq.size() != 4) begin
            errors++;
            $display("FAIL make_break_count: got %0d events, required 4", evq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (evq[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL make_break_ev%0d: got %h, required %h", i, evq[i], exp[i]);
                end
            end
        end
        checks++;
        if (errp != 0) begin
            errors++;
            $display("FAIL make_break_err: kbd_err pulses %0d, required 0", errp);
        end
    endtask

    task automatic test_errors();
        clear_logs();
        send_byte(8'hE0);
        bus.rx_err = 1'b1;
        tick();
        bus.rx_err = 1'b0;
        send_byte(8'h1C);
        repeat (2) tick();
        checks++;
        if (errp != 1 || evq.size() != 1) begin
            errors++;
            $display("FAIL rx_err_seq: err %0d events %0d, required 1 1", errp, evq.size());
        end else begin
            checks++;
            if (evq[0] !== ev_t'{8'h1C, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rx_err_event: got %h, required 1c0", evq[0]);
            end
        end

        clear_logs();
        send_byte(8'hAA);
        send_byte(8'hFA);
        repeat (2) tick();
        checks++;
        if (evq.size() != 0 || errp != 1) begin
            errors++;
            $display("FAIL bat_idle_ack: events %0d err %0d, required 0 1", evq.size(), errp);
        end

        clear_logs();
        send_byte(8'hF0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (2) tick();
        checks++;
        if (errp != 1 || evq.size() != 1) begin
            errors++;
            $display("FAIL double_f0: err %0d events %0d, required 1 1", errp, evq.size());
        end else begin
            checks++;
            if (evq[0] !== ev_t'{8'h1C, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL double_f0_event: got %h, required 1c0", evq[0]);
            end
        end
    endtask

    task automatic test_led_ok();
        clear_logs();
        bus.tx_busy = 1'b1;
        pulse_led(3'b101);
        @(negedge clk);
        checks++;
        if (bus.led_busy !== 1'b1) begin
            errors++;
            $display("FAIL led_busy_rise: got %b, required 1", bus.led_busy);
        end
        repeat (5) tick();
        checks++;
        if (txq.size() != 0) begin
            errors++;
            $display("FAIL tx_busy_hold: tx count %0d, required 0", txq.size());
        end
        bus.tx_busy = 1'b0;
        wait_tx(1, "led_ok_ed");
        repeat (3) tick();
        send_byte(8'hFA);
        wait_tx(2, "led_ok_mask");
        repeat (2) tick();
        send_byte(8'hFA);
        @(negedge clk);
        checks++;
        if (bus.led_busy !== 1'b1) begin
            errors++;
            $display("FAIL led_busy_done: got %b, required 1", bus.led_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.led_busy !== 1'b0 || bus.led_fail !== 1'b0) begin
            errors++;
            $display("FAIL led_ok_end: busy %b fail %b, required 0 0", bus.led_busy, bus.led_fail);
        end
        checks++;
        if (txq.size() != 2 || txq[0] !== 8'hED || txq[1] !== 8'h05) begin
            errors++;
            $display("FAIL led_ok_bytes: count %0d first %h last %h, required 2 ed 05",
                     txq.size(), txq[0], txq[txq.size()-1]);
        end
        checks++;
        if (errp != 0) begin
            errors++;
            $display("FAIL led_ok_err: kbd_err pulses %0d, required 0", errp);
        end
        tick();
    endtask

    task automatic test_timeout();
        clear_logs();
        pulse_led(3'b011);
        wait_tx(3, "timeout_sends");
        repeat (150) tick();
        checks++;
        if (txq.size() != 3) begin
            errors++;
            $display("FAIL timeout_count: tx count %0d, required 3", txq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (txq[i] !== 8'hED) begin
                    errors++;
                    $display("FAIL timeout_byte%0d: got %h, required ed", i, txq[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (txcyc[i] - txcyc[i-1] != 100) begin
                    errors++;
                    $display("FAIL timeout_gap%0d: got %0d cycles, required 100", i, txcyc[i] - txcyc[i-1]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.led_fail !== 1'b1 || bus.led_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_end: fail %b busy %b, required 1 0", bus.led_fail, bus.led_busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[5];
        exp = '{8'hED, 8'hED, 8'h01, 8'hED, 8'h02};
        clear_logs();
        pulse_led(3'b001);
        @(negedge clk);
        checks++;
        if (bus.led_fail !== 1'b0) begin
            errors++;
            $display("FAIL led_fail_clear: got %b, required 0", bus.led_fail);
        end
        watch_busy = 1'b1;
        wait_tx(1, "b2b_ed1");
        repeat (3) tick();
        send_byte(8'hFE);
        wait_tx(2, "b2b_ed2");
        repeat (2) tick();
        pulse_led(3'b010);
        tick();
        send_byte(8'hFA);
        wait_tx(3, "b2b_mask1");
        repeat (2) tick();
        send_byte(8'hFA);
        wait_tx(4, "b2b_ed3");
        repeat (2) tick();
        send_byte(8'hFA);
        wait_tx(5, "b2b_mask2");
        repeat (2) tick();
        send_byte(8'hFA);
        watch_busy = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (busy_drop != 0) begin
            errors++;
            $display("FAIL b2b_busy_held: led_busy low %0d cycles, required 0", busy_drop);
        end
        checks++;
        if (bus.led_busy !== 1'b0 || bus.led_fail !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: busy %b fail %b, required 0 0", bus.led_busy, bus.led_fail);
        end
        checks++;
        if (txq.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: tx count %0d, required 5", txq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (txq[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h, required %h", i, txq[i], exp[i]);
                end
            end
        end
        checks++;
        if (errp != 0) begin
            errors++;
            $display("FAIL b2b_err: kbd_err pulses %0d, required 0", errp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        pulse_led(3'b111);
        wait_tx(1, "rst_ed");
        tick();
        send_byte(8'hFA);
        wait_tx(2, "rst_mask");
        tick();
        send_byte(8'hF0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs() !== 23'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h, required 0", all_outs());
        end
        tick();
        clear_logs();
        send_byte(8'h1C);
        repeat (150) tick();
        checks++;
        if (evq.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_events: got %0d, required 1", evq.size());
        end else begin
            checks++;
            if (evq[0] !== ev_t'{8'h1C, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_mid_make: got %h, required 1c0", evq[0]);
            end
        end
        checks++;
        if (txq.size() != 0 || bus.led_busy !== 1'b0 || bus.led_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: tx %0d busy %b fail %b, required 0 0 0",
                     txq.size(), bus.led_busy, bus.led_fail);
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        bus.tx_busy  = 1'b0;
        bus.led_req  = 1'b0;
        bus.led_mask = 3'b000;
        test_reset();
        test_latency();
        test_make_break();
        test_errors();
        test_led_ok();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
